// File: rtl/load_align_unit.sv
// load_align_unit: accepts one load, issues a word-aligned memory read, then
// extracts the addressed byte/halfword/word and sign- or zero-extends it.
// Optional feature macro: HOLY_CORE_LOAD_MISALIGN_SPLIT_EN -- when defined,
// misaligned loads are serviced (word-crossing ones with two reads) instead
// of being reported as errors.
module load_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_f3,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [3:0]        mem_rd_strb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic              wb_err
);

    localparam logic [2:0] F3_BYTE       = 3'b000;
    localparam logic [2:0] F3_HALFWORD   = 3'b001;
    localparam logic [2:0] F3_WORD       = 3'b010;
    localparam logic [2:0] F3_BYTE_U     = 3'b100;
    localparam logic [2:0] F3_HALFWORD_U = 3'b101;

`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, REQ2, WAIT2} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [3:0]        rd_strb_q;
    logic [31:0]       wb_data_q;
    logic              wb_err_q;
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
    logic [31:0]       first_q;
`endif

    function automatic logic f3_ok(input logic [2:0] f3);
        return (f3 == F3_BYTE) || (f3 == F3_HALFWORD) || (f3 == F3_WORD) ||
               (f3 == F3_BYTE_U) || (f3 == F3_HALFWORD_U);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_HALFWORD) || (f3 == F3_HALFWORD_U);
    endfunction

    function automatic logic is_word(input logic [2:0] f3);
        return f3 == F3_WORD;
    endfunction

    // Accesses that end the transaction without touching memory.
    function automatic logic is_err(input logic [1:0] off, input logic [2:0] f3);
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
        return !f3_ok(f3) || (off == 2'b11 && !f3_ok(f3));
`else
        return !f3_ok(f3) || (is_half(f3) && off[0]) || (is_word(f3) && off != 2'b00);
`endif
    endfunction

    // Lanes used from the first (or only) word; bits shifted past lane 3 drop off.
    function automatic logic [3:0] strb_first(input logic [1:0] off, input logic [2:0] f3);
        logic [3:0] m;
        if (is_word(f3))      m = 4'b1111;
        else if (is_half(f3)) m = 4'b0011;
        else                  m = 4'b0001;
        return m << off;
    endfunction

`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
    // Access spills into the next word.
    function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
        return (is_half(f3) && off == 2'b11) || (is_word(f3) && off != 2'b00);
    endfunction

    // Low lanes of the following word holding the remaining bytes.
    function automatic logic [3:0] strb_second(input logic [1:0] off, input logic [2:0] f3);
        logic [3:0] m;
        m = 4'b0000;
        if (is_half(f3)) m = 4'b0001;
        else begin
            case (off)
                2'b01:   m = 4'b0001;
                2'b10:   m = 4'b0011;
                2'b11:   m = 4'b0111;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction
`endif

    // Truncate to access size and extend according to funct3.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [31:0]        r;
        sb = raw[7:0];
        sh = raw[15:0];
        case (f3)
            F3_BYTE:       r = 32'(sb);
            F3_HALFWORD:   r = 32'(sh);
            F3_BYTE_U:     r = {24'b0, raw[7:0]};
            F3_HALFWORD_U: r = {16'b0, raw[15:0]};
            default:       r = raw;
        endcase
        return r;
    endfunction

    // Align the addressed bytes down to bit 0 across a pair of words.
    function automatic logic [31:0] merge(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off, input logic [2:0] f3);
        return extend(32'({hi, lo} >> {off, 3'b000}), f3);
    endfunction

    // State register; reset drops any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and state-decoded handshake outputs.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        wb_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = is_err(req_addr[1:0], req_f3) ? DONE : REQ;
            end
            REQ: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) state_d = WAIT;
            end
            WAIT: begin
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
                if (mem_rsp_valid) state_d = crosses(off_q, f3_q) ? REQ2 : DONE;
`else
                if (mem_rsp_valid) state_d = DONE;
`endif
            end
            DONE: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = IDLE;
            end
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
            REQ2: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) state_d = WAIT2;
            end
            WAIT2: begin
                if (mem_rsp_valid) state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read address/lanes and the registered writeback result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            rd_addr_q <= '0;
            rd_strb_q <= 4'b0000;
            wb_data_q <= 32'b0;
            wb_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        off_q <= req_addr[1:0];
                        f3_q  <= req_f3;
                        if (is_err(req_addr[1:0], req_f3)) begin
                            wb_data_q <= 32'b0;
                            wb_err_q  <= 1'b1;
                        end else begin
                            rd_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            rd_strb_q <= strb_first(req_addr[1:0], req_f3);
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
                        if (crosses(off_q, f3_q)) begin
                            rd_addr_q <= rd_addr_q + ADDR_W'(4);
                            rd_strb_q <= strb_second(off_q, f3_q);
                        end else begin
                            wb_data_q <= merge(32'b0, mem_rsp_data, off_q, f3_q);
                            wb_err_q  <= 1'b0;
                        end
`else
                        wb_data_q <= merge(32'b0, mem_rsp_data, off_q, f3_q);
                        wb_err_q  <= 1'b0;
`endif
                    end
                end
`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
                WAIT2: begin
                    if (mem_rsp_valid) begin
                        wb_data_q <= merge(mem_rsp_data, first_q, off_q, f3_q);
                        wb_err_q  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
    // Low word of a split access, held until the second read returns.
    always_ff @(posedge clk) begin
        if (state_q == WAIT && mem_rsp_valid) first_q <= mem_rsp_data;
    end
`endif

    assign mem_rd_addr = rd_addr_q;
    assign mem_rd_strb = rd_strb_q;
    assign wb_data     = wb_data_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed testbench for load_align_unit; honours HOLY_CORE_LOAD_MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic [3:0]  mem_rd_strb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic        wb_err;

    int nvec  = 0;
    int nbad  = 0;
    int nrd   = 0;
    int nrdv  = 0;

    load_align_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_f3(req_f3),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_strb(mem_rd_strb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Count read handshakes and cycles with a read request pending.
    always @(posedge clk) begin
        if (mem_rd_valid && mem_rd_ready) nrd <= nrd + 1;
        if (mem_rd_valid) nrdv <= nrdv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rd_valid"}, 32'(mem_rd_valid), 32'd0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 32'd0);
        chk({tag, "_rd_strb"}, 32'(mem_rd_strb), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_err"}, 32'(wb_err), 32'd0);
    endtask

    // One single-read load with rdly cycles of read backpressure and wdly of writeback backpressure.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] w, input int rdly, input int wdly,
                           input logic [31:0] eaddr, input logic [3:0] estrb,
                           input logic [31:0] edata);
        int r0;
        r0 = nrd;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_f3 = f3;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            chk({tag, "_rdv_hold"}, 32'(mem_rd_valid), 32'd1);
            chk({tag, "_addr_hold"}, mem_rd_addr, eaddr);
            tick();
        end
        chk({tag, "_rdv"}, 32'(mem_rd_valid), 32'd1);
        chk({tag, "_addr"}, mem_rd_addr, eaddr);
        chk({tag, "_strb"}, 32'(mem_rd_strb), 32'(estrb));
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        chk({tag, "_rdv_drop"}, 32'(mem_rd_valid), 32'd0);
        chk({tag, "_wbv_early"}, 32'(wb_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = w;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < wdly; i++) begin
            chk({tag, "_wbv_hold"}, 32'(wb_valid), 32'd1);
            chk({tag, "_data_hold"}, wb_data, edata);
            chk({tag, "_err_hold"}, 32'(wb_err), 32'd0);
            tick();
        end
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_data, edata);
        chk({tag, "_err"}, 32'(wb_err), 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({tag, "_wbv_done"}, 32'(wb_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, "_nreads"}, 32'(nrd - r0), 32'd1);
    endtask

    // Load that must be rejected with an error and no memory traffic.
    task automatic err_load(input string tag, input logic [31:0] a, input logic [2:0] f3);
        int r0;
        r0 = nrdv;
        req_valid = 1'b1; req_addr = a; req_f3 = f3;
        tick();
        req_valid = 1'b0;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_err"}, 32'(wb_err), 32'd1);
        chk({tag, "_data"}, wb_data, 32'd0);
        chk({tag, "_rdv"}, 32'(mem_rd_valid), 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({tag, "_wbv_done"}, 32'(wb_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, "_no_read"}, 32'(nrdv - r0), 32'd0);
    endtask

    initial begin
        int r0;
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_f3 = 3'd0;
        mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; wb_ready = 1'b0;
        tick();
        chk_reset_vals("por");
        tick();
        rst = 1'b0;
        tick();

        do_load("lb_103", 32'h0000_0103, 3'b000, 32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        do_load("lhu_202", 32'h0000_0202, 3'b101, 32'hBEEF_0001, 0, 0, 32'h0000_0200, 4'b1100, 32'h0000_BEEF);
        do_load("lh_202", 32'h0000_0202, 3'b001, 32'hBEEF_0001, 0, 0, 32'h0000_0200, 4'b1100, 32'hFFFF_BEEF);
        err_load("f3_011", 32'h0000_0300, 3'b011);
        err_load("f3_110", 32'h0000_0300, 3'b110);
        err_load("f3_111", 32'h0000_0300, 3'b111);
        do_load("lw_bp", 32'h0000_0400, 3'b010, 32'h1234_5678, 3, 2, 32'h0000_0400, 4'b1111, 32'h1234_5678);
        do_load("lbu_001", 32'h0000_0001, 3'b100, 32'h0000_A500, 0, 0, 32'h0000_0000, 4'b0010, 32'h0000_00A5);
        do_load("lb_001", 32'h0000_0001, 3'b000, 32'h0000_A500, 0, 1, 32'h0000_0000, 4'b0010, 32'hFFFF_FFA5);
        do_load("lh_006", 32'h0000_0006, 3'b001, 32'h7FFF_0000, 1, 0, 32'h0000_0004, 4'b1100, 32'h0000_7FFF);

        // Reset while waiting for the response; the late response must be ignored.
        req_valid = 1'b1; req_addr = 32'h0000_0500; req_f3 = 3'b010;
        tick();
        req_valid = 1'b0;
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        chk("rst_in_wait_rdv", 32'(mem_rd_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        chk_reset_vals("stale_rsp");
        tick();
        chk("stale_rsp_wbv2", 32'(wb_valid), 32'd0);
        do_load("after_rst", 32'h0000_0502, 3'b101, 32'h5A5A_0000, 0, 0, 32'h0000_0500, 4'b1100, 32'h0000_5A5A);

`ifdef HOLY_CORE_LOAD_MISALIGN_SPLIT_EN
        r0 = nrd;
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_f3 = 3'b010;
        tick();
        req_valid = 1'b0;
        chk("split_rdv1", 32'(mem_rd_valid), 32'd1);
        chk("split_addr1", mem_rd_addr, 32'hFFFF_FFFC);
        chk("split_strb1", 32'(mem_rd_strb), 32'h0000_000C);
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAABB_CCDD;
        tick();
        mem_rsp_valid = 1'b0;
        chk("split_rdv2", 32'(mem_rd_valid), 32'd1);
        chk("split_addr2", mem_rd_addr, 32'h0000_0000);
        chk("split_strb2", 32'(mem_rd_strb), 32'h0000_0003);
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        chk("split_wbv_early", 32'(wb_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1122_3344;
        tick();
        mem_rsp_valid = 1'b0;
        chk("split_wbv", 32'(wb_valid), 32'd1);
        chk("split_data", wb_data, 32'h3344_AABB);
        chk("split_err", 32'(wb_err), 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("split_nreads", 32'(nrd - r0), 32'd2);
        do_load("lh_off1", 32'h0000_0001, 3'b001, 32'h00AB_CD00, 0, 0, 32'h0000_0000, 4'b0110, 32'hFFFF_ABCD);
`else
        r0 = nrd;
        err_load("lw_301", 32'h0000_0301, 3'b010);
        err_load("lw_wrap", 32'hFFFF_FFFE, 3'b010);
        err_load("lh_off1", 32'h0000_0001, 3'b001);
        err_load("lhu_off3", 32'h0000_0003, 3'b101);
        chk("mis_nreads", 32'(nrd - r0), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Load-side counterpart of the store byte-lane decoder. It accepts one load request from the core, issues a word-aligned read to data memory, then extracts the addressed byte, halfword or word and sign- or zero-extends it per funct3. It returns the result on a writeback handshake. It sits between the core's memory stage and the data-memory read port, mirroring the store path's lane and offset rules.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the request and memory ports.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  core presents a load.
- req_ready  out  1  unit can accept a load; high only in IDLE.
- req_addr  in  ADDR_W  byte address of the load.
- req_f3  in  3  funct3, using the holy_core_pkg encodings: F3_BYTE=000, F3_HALFWORD=001, F3_WORD=010, F3_BYTE_U=100, F3_HALFWORD_U=101.
- mem_rd_valid  out  1  read request to memory.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_addr  out  ADDR_W  word-aligned read address; bits [1:0] are always 00.
- mem_rd_strb  out  4  byte lanes actually consumed by this read.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  32  read word, little-endian lanes.
- wb_valid  out  1  result available.
- wb_ready  in  1  core consumes the result.
- wb_data  out  32  aligned and extended load value.
- wb_err  out  1  misaligned access or unsupported f3; qualified by wb_valid.

## Operation
- State machine states: IDLE, REQ, WAIT, DONE; REQ2 and WAIT2 exist only with the macro.
- IDLE: when req_valid is high, latch addr and f3, then classify the access.
  - Unsupported f3 (011, 110, 111), or misaligned: go to DONE with wb_err=1 and wb_data=0. No memory access is made.
  - Otherwise go to REQ.
- Misaligned (macro off): halfword with addr[0]=1, or word with addr[1:0]≠00.
- REQ: mem_rd_valid=1 and mem_rd_addr={addr[ADDR_W-1:2],2'b00}. Hold both until mem_rd_ready; then go to WAIT.
- WAIT: capture mem_rsp_data when mem_rsp_valid is high, then go to DONE. mem_rsp_valid is ignored in every other state.
- Extraction uses off=addr[1:0]:
  - Byte: lane off.
  - Halfword: lanes off..off+1.
  - Word: all lanes.
- Extension: F3_BYTE and F3_HALFWORD sign-extend from bit 7 or bit 15. F3_BYTE_U and F3_HALFWORD_U zero-extend.
- mem_rd_strb values:
  - Byte: 0001<<off.
  - Halfword: 0011<<off.
  - Word: 1111.
- DONE: wb_valid=1, with wb_data and wb_err held stable until wb_ready. Then return to IDLE.
- Reset mid-operation: the state machine goes immediately to IDLE and the outstanding request is dropped. A response arriving after reset is ignored.

## Timing
- Reset values: req_ready=1, mem_rd_valid=0, mem_rd_addr=0, mem_rd_strb=0, wb_valid=0, wb_data=0, wb_err=0.
- Request accepted in cycle 0 means mem_rd_valid is high in cycle 1.
- Best case: mem_rd_ready is high in cycle 1 and mem_rsp_valid is high in cycle 2. The result is captured at that edge, and wb_valid is high in cycle 3. Minimum latency is 3 cycles.
- Error path: wb_valid is high in cycle 1.
- Memory must assert mem_rsp_valid no earlier than the cycle after the read handshake.
- There is no back-to-back acceptance: req_ready rises in the cycle after the wb handshake. Throughput is 1 load per 4 cycles at best.
- All outputs are registered, or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- HOLY_CORE_LOAD_MISALIGN_SPLIT_EN defined: misaligned accesses that fit within one word (halfword with off=1) complete as a single read.
- Accesses that cross a word (halfword off=3; word off≠0) take two reads:
  - First read: REQ/WAIT at base=addr&~3, with strb=1111<<off (truncated to 4 bits).
  - Second read: REQ2/WAIT2 at base+4, wrapping modulo 2^ADDR_W, with strb=low (off+size-4) bits set.
  - Merge: result = ({second,first}>>(8*off)), truncated to size, then extended.
  - wb_err=0 for these accesses.
- Macro not defined: every misaligned halfword or word load gives wb_err=1 with no memory access. REQ2 and WAIT2 do not exist.

## Test plan
- LB at addr 0x103, mem word 0x80FF_1234 -> rd addr 0x100, strb 1000, wb_data 0xFFFF_FF80, wb_err 0, wb_valid in cycle 3.
- LHU at 0x202, mem word 0xBEEF_0001 -> strb 1100, wb_data 0x0000_BEEF. LH at the same address -> wb_data 0xFFFF_BEEF.
- LW at 0x301 with the macro off -> wb_valid cycle 1, wb_err 1, wb_data 0, mem_rd_valid never asserted. req_f3=011 -> same response.
- Backpressure: mem_rd_ready low for 3 cycles, then wb_ready low for 2 cycles -> mem_rd_addr, wb_data and wb_err stay stable, with exactly one read issued.
- rst pulsed in WAIT, then a stale mem_rsp_valid -> all outputs at reset values, no wb_valid, and a new request is accepted normally.
- Macro on: LW at 0xFFFF_FFFE, words 0xAABB_CCDD at 0xFFFF_FFFC and 0x1122_3344 at 0x0 -> reads to 0xFFFF_FFFC (strb 1100) and 0x0000_0000 (strb 0011), wb_data 0x3344_AABB, wb_err 0.
